// File: rtl/fixed_point_unit_arbiter.sv
// fixed_point_unit_arbiter: round-robin sharing of one Fixed_Point_Unit between two requesters.
// Optional macro FPU_TIMEOUT_EN adds a WAIT-cycle watchdog that aborts a stuck op with error=1.

module fixed_point_unit_arbiter #(
    parameter int WIDTH          = 32,
    parameter int FLUSH_CYCLES   = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    input  logic [1:0]       req0_operation,
    input  logic [WIDTH-1:0] req0_operand_1,
    input  logic [WIDTH-1:0] req0_operand_2,
    output logic             req0_accept,
    output logic             req0_done,

    input  logic             req1_valid,
    input  logic [1:0]       req1_operation,
    input  logic [WIDTH-1:0] req1_operand_1,
    input  logic [WIDTH-1:0] req1_operand_2,
    output logic             req1_accept,
    output logic             req1_done,

    output logic [WIDTH-1:0] result,
    output logic             error,
    output logic             busy,

    output logic [1:0]       fpu_operation,
    output logic [WIDTH-1:0] fpu_operand_1,
    output logic [WIDTH-1:0] fpu_operand_2,
    input  logic [WIDTH-1:0] fpu_result,
    input  logic             fpu_ready,

    output logic [1:0]       dbg_state
);

    // Opcode encoding shared with the FPU's Defines.vh; ADD with zero operands is the idle/flush op.
    localparam logic [1:0] FPU_ADD = 2'b00;

    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic             r_rr;        // 1: requester 1 wins a tie
    logic             r_owner;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_opnd_1;
    logic [WIDTH-1:0] r_opnd_2;
    logic [WIDTH-1:0] r_result;
    logic             r_done0;
    logic             r_done1;
    logic [FCW-1:0]   r_flush_cnt;

    logic             w_grant0;
    logic             w_grant1;
    logic             w_accept;
    logic             w_complete;
    logic             w_abort;
    logic             w_tmo_hit;

    // Handshake: reqN_valid with operands is held by the requester until reqN_accept=1 (comb.,
    // IDLE only); the op is captured at that same clock edge and the inputs are ignored afterwards.
    assign w_grant0 = reset && (r_state == S_IDLE) && req0_valid && (!req1_valid || !r_rr);
    assign w_grant1 = reset && (r_state == S_IDLE) && req1_valid && (!req0_valid ||  r_rr);
    assign w_accept = w_grant0 || w_grant1;

    // A ready in the last allowed WAIT cycle still counts as a normal completion.
    assign w_complete = (r_state == S_WAIT) && fpu_ready;
    assign w_abort    = (r_state == S_WAIT) && !fpu_ready && w_tmo_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        req0_accept   = 1'b0;
        req1_accept   = 1'b0;
        busy          = 1'b0;
        fpu_operation = FPU_ADD;
        fpu_operand_1 = '0;
        fpu_operand_2 = '0;
        case (r_state)
            S_IDLE: begin
                req0_accept = w_grant0;
                req1_accept = w_grant1;
                if (w_accept) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                busy          = 1'b1;
                fpu_operation = r_op;
                fpu_operand_1 = r_opnd_1;
                fpu_operand_2 = r_opnd_2;
                if (w_complete || w_abort) begin
                    w_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                busy = 1'b1;
                if (r_flush_cnt == FLUSH_LAST) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr        <= 1'b0;
            r_owner     <= 1'b0;
            r_op        <= FPU_ADD;
            r_opnd_1    <= '0;
            r_opnd_2    <= '0;
            r_result    <= '0;
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
            r_flush_cnt <= '0;
        end else begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;

            if (w_accept) begin
                r_owner  <= w_grant1;
                r_rr     <= w_grant0;
                r_op     <= w_grant1 ? req1_operation : req0_operation;
                r_opnd_1 <= w_grant1 ? req1_operand_1 : req0_operand_1;
                r_opnd_2 <= w_grant1 ? req1_operand_2 : req0_operand_2;
            end

            if (w_complete || w_abort) begin
                r_result <= w_complete ? fpu_result : '0;
                r_done0  <= !r_owner;
                r_done1  <=  r_owner;
            end

            if (r_state == S_FLUSH) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end else begin
                r_flush_cnt <= '0;
            end
        end
    end

`ifdef FPU_TIMEOUT_EN
    localparam int TCW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_CYCLES - 1);

    logic [TCW-1:0] r_tmo_cnt;
    logic           r_error;

    assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);
    assign error     = r_error;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tmo_cnt <= '0;
            r_error   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_tmo_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end

            if (w_abort) begin
                r_error <= 1'b1;
            end else if (w_complete) begin
                r_error <= 1'b0;
            end
        end
    end
`else
    logic w_unused_tmo;

    assign w_tmo_hit    = 1'b0;
    assign error        = 1'b0;
    assign w_unused_tmo = ^TIMEOUT_CYCLES;
`endif

    assign result    = r_result;
    assign req0_done = r_done0;
    assign req1_done = r_done1;
    assign dbg_state = r_state;

    // Structural invariants of the arbitration.
    a_done_excl: assert property (@(posedge clk) disable iff (!reset) !(r_done0 && r_done1));
    a_accept_excl: assert property (@(posedge clk) disable iff (!reset) !(req0_accept && req1_accept));

endmodule
